// File: rtl/ltl_nfa_monitor_pkg.sv
// Shared definitions for the programmable LTL NFA monitor: config selectors,
// attribute bit positions and width helpers.
package ltl_mon_pkg;

    typedef enum logic [1:0] {
        CFG_TERM = 2'd0,
        CFG_EDGE = 2'd1,
        CFG_ATTR = 2'd2,
        CFG_RSVD = 2'd3
    } cfg_sel_e;

    localparam int unsigned ATTR_START  = 0;
    localparam int unsigned ATTR_ALLIN  = 1;
    localparam int unsigned ATTR_REPORT = 2;
    localparam int unsigned ATTR_W      = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ltl_nfa_monitor_if.sv
// Symbol input and report output handshakes of the NFA monitor.
interface ltl_nfa_monitor_if #(
    parameter int unsigned SYM_W    = 8,
    parameter int unsigned N_STATES = 16,
    parameter int unsigned CNT_W    = 32
);
    logic                      sym_valid;
    logic [SYM_W-1:0]          sym_data;
    logic                      sym_ready;
    logic                      rep_valid;
    logic                      rep_ready;
    logic [CNT_W+N_STATES-1:0] rep_data;

    modport master (
        output sym_valid, sym_data, rep_ready,
        input  sym_ready, rep_valid, rep_data
    );

    modport slave (
        input  sym_valid, sym_data, rep_ready,
        output sym_ready, rep_valid, rep_data
    );
endinterface

// File: rtl/ltl_nfa_monitor_report_fifo.sv
// Synchronous report FIFO with async reset and synchronous flush; rdata reads 0 when empty.
module ltl_report_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop on the same edge frees the slot being written when full.
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/ltl_nfa_monitor.sv
// Runtime-programmable NFA monitor: ternary-matched STEs with configurable edges,
// start/report attributes, sticky reports, symbol counter and report event FIFO.
module ltl_nfa_monitor
    import ltl_mon_pkg::*;
#(
    parameter int unsigned N_STATES      = 16,
    parameter int unsigned SYM_W         = 8,
    parameter int unsigned N_TERMS       = 4,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned CNT_W         = 32,
    parameter bit          STALL_ON_FULL = 1'b1,
    localparam int unsigned ST_AW  = $clog2(N_STATES),
    localparam int unsigned TM_AW  = $clog2(N_TERMS),
    localparam int unsigned ADDR_W = 2 + ST_AW + TM_AW,
    localparam int unsigned CFG_W  = max_u(2*SYM_W + 1, N_STATES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                soft_clear,
    input  logic                enable,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [CFG_W-1:0]    cfg_wdata,
    ltl_nfa_monitor_if.slave    bus,
    output logic [N_STATES-1:0] report_vec,
    output logic [N_STATES-1:0] sticky_report,
    output logic [CNT_W-1:0]    sym_count,
    output logic                rep_overflow
);
    typedef struct packed {
        logic             valid;
        logic [SYM_W-1:0] care;
        logic [SYM_W-1:0] value;
    } term_t;

    localparam int unsigned REP_W = CNT_W + N_STATES;

    term_t [N_STATES-1:0][N_TERMS-1:0] terms;
    logic  [N_STATES-1:0][N_STATES-1:0] pred;
    logic  [N_STATES-1:0][ATTR_W-1:0]   attr;

    cfg_sel_e          cfg_sel;
    logic [ST_AW-1:0]  cfg_state;
    logic [TM_AW-1:0]  cfg_term;
    logic              cfg_in_range;

    assign cfg_sel      = cfg_sel_e'(cfg_addr[ADDR_W-1 -: 2]);
    assign cfg_state    = cfg_addr[TM_AW +: ST_AW];
    assign cfg_term     = cfg_addr[TM_AW-1:0];
    assign cfg_in_range = (32'(cfg_state) < N_STATES) && (32'(cfg_term) < N_TERMS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            terms <= '0;
            pred  <= '0;
            attr  <= '0;
        end else if (cfg_we && cfg_in_range) begin
            case (cfg_sel)
                CFG_TERM: terms[cfg_state][cfg_term] <= term_t'(cfg_wdata[2*SYM_W:0]);
                CFG_EDGE: pred[cfg_state]             <= cfg_wdata[N_STATES-1:0];
                CFG_ATTR: attr[cfg_state]             <= cfg_wdata[ATTR_W-1:0];
                default: ;
            endcase
        end
    end

    logic                fifo_full, fifo_empty;
    logic                accept, push, pop, first_flag;
    logic [N_STATES-1:0] active, active_next, report_next;

    assign bus.sym_ready = enable & ~cfg_we & ~soft_clear & ~(STALL_ON_FULL & fifo_full);
    assign accept        = bus.sym_valid & bus.sym_ready;
    assign pop           = bus.rep_ready & ~fifo_empty;
    assign bus.rep_valid = ~fifo_empty;
    assign push          = accept & (|report_next);

    for (genvar s = 0; s < N_STATES; s++) begin : g_ste
        logic hit, en;
        always_comb begin
            hit = 1'b0;
            for (int unsigned t = 0; t < N_TERMS; t++)
                hit |= terms[s][t].valid &
                       (((bus.sym_data ^ terms[s][t].value) & terms[s][t].care) == '0);
        end
        assign en = (attr[s][ATTR_START] & first_flag) | attr[s][ATTR_ALLIN] | (|(active & pred[s]));
        assign active_next[s] = en & hit;
        assign report_next[s] = active_next[s] & attr[s][ATTR_REPORT];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active        <= '0;
            report_vec    <= '0;
            sticky_report <= '0;
            sym_count     <= '0;
            first_flag    <= 1'b1;
            rep_overflow  <= 1'b0;
        end else if (soft_clear) begin
            active        <= '0;
            report_vec    <= '0;
            sticky_report <= '0;
            sym_count     <= '0;
            first_flag    <= 1'b1;
            rep_overflow  <= 1'b0;
        end else begin
            if (accept) begin
                active        <= active_next;
                report_vec    <= report_next;
                sticky_report <= sticky_report | report_next;
                sym_count     <= sym_count + CNT_W'(1);
                first_flag    <= 1'b0;
            end
            // Only reachable in drop mode: stall mode never accepts while full.
            if (push && fifo_full && !pop) rep_overflow <= 1'b1;
        end
    end

    ltl_report_fifo #(
        .WIDTH (REP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (soft_clear),
        .push  (push),
        .wdata ({sym_count, report_next}),
        .pop   (pop),
        .rdata (bus.rep_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_ltl_nfa_monitor.sv
// Scoreboard bench: stall-mode and drop-mode monitors share stimulus and are checked
// against a set-based NFA reference model.
module tb_ltl_nfa_monitor;
    import ltl_mon_pkg::*;

    localparam int NS = 16, SW = 8, NT = 4, FD = 8, CW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, soft_clear, enable, cfg_we;
    logic [7:0]  cfg_addr;
    logic [16:0] cfg_wdata;
    logic        sym_valid, rep_ready;
    logic [7:0]  sym_data;

    logic [15:0] rvec_o [2];
    logic [15:0] stk_o  [2];
    logic [31:0] cnt_o  [2];
    logic        ovf_o  [2];
    logic        rdy_o  [2];
    logic        rv_o   [2];
    logic [47:0] rd_o   [2];

    ltl_nfa_monitor_if #(.SYM_W(SW), .N_STATES(NS), .CNT_W(CW)) bus0 ();
    ltl_nfa_monitor_if #(.SYM_W(SW), .N_STATES(NS), .CNT_W(CW)) bus1 ();

    assign bus0.sym_valid = sym_valid;
    assign bus0.sym_data  = sym_data;
    assign bus0.rep_ready = rep_ready;
    assign bus1.sym_valid = sym_valid;
    assign bus1.sym_data  = sym_data;
    assign bus1.rep_ready = rep_ready;
    assign rdy_o[0] = bus0.sym_ready;
    assign rv_o[0]  = bus0.rep_valid;
    assign rd_o[0]  = bus0.rep_data;
    assign rdy_o[1] = bus1.sym_ready;
    assign rv_o[1]  = bus1.rep_valid;
    assign rd_o[1]  = bus1.rep_data;

    ltl_nfa_monitor #(
        .N_STATES(NS), .SYM_W(SW), .N_TERMS(NT), .FIFO_DEPTH(FD), .CNT_W(CW), .STALL_ON_FULL(1'b1)
    ) u_dut_stall (
        .clk(clk), .reset(reset), .soft_clear(soft_clear), .enable(enable), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .bus(bus0.slave), .report_vec(rvec_o[0]),
        .sticky_report(stk_o[0]), .sym_count(cnt_o[0]), .rep_overflow(ovf_o[0])
    );

    ltl_nfa_monitor #(
        .N_STATES(NS), .SYM_W(SW), .N_TERMS(NT), .FIFO_DEPTH(FD), .CNT_W(CW), .STALL_ON_FULL(1'b0)
    ) u_dut_drop (
        .clk(clk), .reset(reset), .soft_clear(soft_clear), .enable(enable), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .bus(bus1.slave), .report_vec(rvec_o[1]),
        .sticky_report(stk_o[1]), .sym_count(cnt_o[1]), .rep_overflow(ovf_o[1])
    );

    // Reference configuration tables
    bit [15:0] m_pred  [NS];
    bit [7:0]  m_care  [NS][NT];
    bit [7:0]  m_val   [NS][NT];
    bit        m_tv    [NS][NT];
    bit        m_start [NS];
    bit        m_allin [NS];
    bit        m_rep   [NS];

    typedef struct {
        bit [15:0] active, rvec, sticky;
        bit [31:0] count;
        bit        first, ovf;
        int        occ;
    } mst_t;
    mst_t ms [2];

    bit [47:0] q0 [$];
    bit [47:0] q1 [$];
    int checks = 0, errors = 0;

    function automatic void chk(string name, int inst, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, inst, act, exp, $time);
        end
    endfunction

    function automatic void clear_run();
        for (int i = 0; i < 2; i++) begin
            ms[i].active = '0; ms[i].rvec = '0; ms[i].sticky = '0;
            ms[i].count = '0; ms[i].first = 1'b1; ms[i].ovf = 1'b0; ms[i].occ = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    function automatic void clear_cfg();
        for (int s = 0; s < NS; s++) begin
            m_pred[s] = '0; m_start[s] = 0; m_allin[s] = 0; m_rep[s] = 0;
            for (int t = 0; t < NT; t++) begin
                m_care[s][t] = '0; m_val[s][t] = '0; m_tv[s][t] = 0;
            end
        end
    endfunction

    // A state is entered when it may start or has an active predecessor, and is kept if any term accepts sym.
    function automatic bit [15:0] nfa_next(bit [15:0] act, bit first, bit [7:0] sym);
        bit [15:0] r = '0;
        for (int s = 0; s < NS; s++) begin
            bit entered = (m_start[s] && first) || m_allin[s] || ((act & m_pred[s]) != 0);
            bit matched = 0;
            for (int t = 0; t < NT; t++)
                if (m_tv[s][t] && ((sym & m_care[s][t]) == (m_val[s][t] & m_care[s][t]))) matched = 1;
            r[s] = entered && matched;
        end
        return r;
    endfunction

    function automatic bit exp_ready(int i);
        return enable && !cfg_we && !soft_clear && !(i == 0 && ms[i].occ == FD);
    endfunction

    function automatic void model_step();
        bit [15:0] mask = '0;
        for (int s = 0; s < NS; s++) mask[s] = m_rep[s];
        if (soft_clear) clear_run();
        else begin
            for (int i = 0; i < 2; i++) begin
                bit acc = sym_valid && exp_ready(i);
                bit pop = rep_ready && ms[i].occ > 0;
                int pushed = 0;
                if (acc) begin
                    bit [15:0] nxt = nfa_next(ms[i].active, ms[i].first, sym_data);
                    bit [15:0] rep = nxt & mask;
                    if (rep != 0) begin
                        if (ms[i].occ < FD || pop) begin
                            if (i == 0) q0.push_back({ms[i].count, rep});
                            else        q1.push_back({ms[i].count, rep});
                            pushed = 1;
                        end else ms[i].ovf = 1'b1;
                    end
                    ms[i].rvec   = rep;
                    ms[i].sticky = ms[i].sticky | rep;
                    ms[i].count  = ms[i].count + 1;
                    ms[i].first  = 1'b0;
                    ms[i].active = nxt;
                end
                ms[i].occ = ms[i].occ - int'(pop) + pushed;
            end
        end
        if (cfg_we) begin
            int st = int'(cfg_addr[5:2]);
            int tm = int'(cfg_addr[1:0]);
            case (cfg_addr[7:6])
                2'd0: begin
                    m_tv[st][tm] = cfg_wdata[16]; m_care[st][tm] = cfg_wdata[15:8]; m_val[st][tm] = cfg_wdata[7:0];
                end
                2'd1: m_pred[st] = cfg_wdata[15:0];
                2'd2: begin
                    m_start[st] = cfg_wdata[0]; m_allin[st] = cfg_wdata[1]; m_rep[st] = cfg_wdata[2];
                end
                default: ;
            endcase
        end
    endfunction

    task automatic cycle();
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("sym_ready", i, rdy_o[i], exp_ready(i));
            chk("report_vec", i, rvec_o[i], ms[i].rvec);
            chk("sticky_report", i, stk_o[i], ms[i].sticky);
            chk("sym_count", i, cnt_o[i], ms[i].count);
            chk("rep_valid", i, rv_o[i], ms[i].occ > 0);
            chk("rep_overflow", i, ovf_o[i], ms[i].ovf);
        end
        if (!reset) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        sym_valid = 1'b1;
        sym_data  = d;
        cycle();
        sym_valid = 1'b0;
    endtask

    task automatic cfg_w(input cfg_sel_e sel, input int st, input int tm, input logic [16:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = {sel, 4'(st), 2'(tm)};
        cfg_wdata = d;
        cycle();
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_soft_clear();
        soft_clear = 1'b1;
        cycle();
        soft_clear = 1'b0;
    endtask

    initial begin : mon0
        forever begin
            @(negedge clk);
            if (rv_o[0] === 1'b1 && rep_ready === 1'b1) begin
                if (q0.size() == 0) chk("rep_unexpected", 0, rd_o[0], 64'hDEAD_0000_0000_0000);
                else                chk("rep_data", 0, rd_o[0], q0.pop_front());
            end
        end
    end

    initial begin : mon1
        forever begin
            @(negedge clk);
            if (rv_o[1] === 1'b1 && rep_ready === 1'b1) begin
                if (q1.size() == 0) chk("rep_unexpected", 1, rd_o[1], 64'hDEAD_0000_0000_0000);
                else                chk("rep_data", 1, rd_o[1], q1.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; soft_clear = 1'b0; enable = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; sym_valid = 1'b0; sym_data = '0; rep_ready = 1'b0;
        clear_run();
        clear_cfg();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_report_vec", i, rvec_o[i], 0);
            chk("rst_sticky", i, stk_o[i], 0);
            chk("rst_count", i, cnt_o[i], 0);
            chk("rst_rep_valid", i, rv_o[i], 0);
            chk("rst_overflow", i, ovf_o[i], 0);
        end
        reset  = 1'b0;
        enable = 1'b1;
        cycle();
        for (int i = 0; i < 2; i++) chk("idle_ready", i, rdy_o[i], 1);

        send(8'h11); send(8'h22); send(8'h33);
        for (int i = 0; i < 2; i++) begin
            chk("nocfg_count", i, cnt_o[i], 3);
            chk("nocfg_report_vec", i, rvec_o[i], 0);
        end

        // Single start state with report
        cfg_w(CFG_TERM, 0, 0, {1'b1, 8'h30, 8'h00});
        cfg_w(CFG_ATTR, 0, 0, 17'h5);
        pulse_soft_clear();
        send(8'h4A);
        for (int i = 0; i < 2; i++) begin
            chk("start_report_vec", i, rvec_o[i], 16'h0001);
            chk("start_fifo_head", i, rd_o[i], {32'd0, 16'h0001});
        end
        send(8'h0A);
        for (int i = 0; i < 2; i++) begin
            chk("start_once_report_vec", i, rvec_o[i], 0);
            chk("start_once_sticky", i, stk_o[i], 16'h0001);
        end

        // Two-state chain s0 -> s1
        cfg_w(CFG_ATTR, 0, 0, 17'h1);
        cfg_w(CFG_EDGE, 1, 0, 17'h0001);
        cfg_w(CFG_TERM, 1, 0, {1'b1, 8'h30, 8'h10});
        cfg_w(CFG_ATTR, 1, 0, 17'h4);
        pulse_soft_clear();
        send(8'h05);
        send(8'h15);
        for (int i = 0; i < 2; i++) chk("chain_fifo_head", i, rd_o[i], {32'd1, 16'h0002});
        rep_ready = 1'b1;
        cycle();
        rep_ready = 1'b0;

        // Fill the FIFO with an always-matching all-input state
        cfg_w(CFG_TERM, 0, 0, {1'b1, 8'h00, 8'h00});
        cfg_w(CFG_ATTR, 0, 0, 17'h6);
        cfg_w(CFG_ATTR, 1, 0, 17'h0);
        pulse_soft_clear();
        sym_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            sym_data = 8'($urandom);
            cycle();
        end
        chk("full_stall_ready", 0, rdy_o[0], 0);
        chk("full_stall_count", 0, cnt_o[0], 8);
        chk("drop_count", 1, cnt_o[1], 9);
        chk("drop_overflow", 1, ovf_o[1], 1);
        sym_valid = 1'b0;
        rep_ready = 1'b1;
        cycle();
        rep_ready = 1'b0;
        chk("pop_unstall_ready", 0, rdy_o[0], 1);
        rep_ready = 1'b1;
        repeat (10) cycle();
        rep_ready = 1'b0;

        // Randomized traffic with config rewrites and soft clears
        pulse_soft_clear();
        for (int n = 0; n < 600; n++) begin
            cfg_we     = ($urandom_range(0, 9) == 0);
            cfg_addr   = 8'($urandom);
            cfg_wdata  = {1'($urandom_range(0, 3) != 0), 8'($urandom & $urandom), 8'($urandom)};
            soft_clear = ($urandom_range(0, 49) == 0);
            enable     = ($urandom_range(0, 9) != 0);
            sym_valid  = ($urandom_range(0, 9) < 7);
            sym_data   = 8'($urandom);
            rep_ready  = 1'($urandom_range(0, 1));
            cycle();
        end
        cfg_we = 1'b0; soft_clear = 1'b0; enable = 1'b1; sym_valid = 1'b0; rep_ready = 1'b0;

        // Asynchronous reset between edges
        cfg_w(CFG_TERM, 0, 0, {1'b1, 8'h00, 8'h00});
        cfg_w(CFG_ATTR, 0, 0, 17'h6);
        send(8'h01); send(8'h02); send(8'h03);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_rst_report_vec", i, rvec_o[i], 0);
            chk("async_rst_sticky", i, stk_o[i], 0);
            chk("async_rst_count", i, cnt_o[i], 0);
            chk("async_rst_rep_valid", i, rv_o[i], 0);
            chk("async_rst_rep_data", i, rd_o[i], 0);
        end
        clear_run();
        clear_cfg();
        cycle();
        reset = 1'b0;
        send(8'h00);
        send(8'h55);
        for (int i = 0; i < 2; i++) begin
            chk("post_rst_report_vec", i, rvec_o[i], 0);
            chk("post_rst_rep_valid", i, rv_o[i], 0);
            chk("post_rst_count", i, cnt_o[i], 2);
        end

        rep_ready = 1'b1;
        repeat (12) cycle();
        chk("scoreboard_drained", 0, q0.size(), 0);
        chk("scoreboard_drained", 1, q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
